// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_pkg
// Description : Shared types and helpers for the data-memory wait responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_pkg;

    localparam int BE_W   = 4;
    localparam int LANE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } dm_state_e;

    function automatic logic [BE_W*LANE_W-1:0] be_merge(
        input logic [BE_W*LANE_W-1:0] old_word,
        input logic [BE_W*LANE_W-1:0] wdata,
        input logic [BE_W-1:0]        be
    );
        logic [BE_W*LANE_W-1:0] res;
        res = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) res[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_ram_array.sv
`default_nettype none
// ============================================================================
// Module      : dm_ram_array
// Description : DEPTH x 32 synchronous RAM, per-byte write strobe, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_ram_array
    import dm_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic                   clk,
    input  logic [BE_W-1:0]        i_wr_be,
    input  logic                   i_rd_en,
    input  logic [IDX_W-1:0]       i_addr,
    input  logic [BE_W*LANE_W-1:0] i_wdata,
    output logic [BE_W*LANE_W-1:0] o_rdata
);

    logic [BE_W*LANE_W-1:0] r_mem [DEPTH];
    logic [BE_W*LANE_W-1:0] r_rdata;

    // Contents are deliberately not reset; only the strobed lanes change.
    always_ff @(posedge clk) begin
        if (|i_wr_be) r_mem[i_addr] <= be_merge(r_mem[i_addr], i_wdata, i_wr_be);
        if (i_rd_en)  r_rdata       <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dm_wait_responder.sv
`default_nettype none
// ============================================================================
// Module      : dm_wait_responder
// Description : Valid/ready data-memory responder with configurable wait states.
//               Define DM_ERR_EN to flag out-of-range addresses instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_wait_responder
    import dm_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int         c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] c_WAIT  = 4'(WAIT_CYCLES);

    dm_state_e r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;
    logic              r_rsp_load;

    logic               w_accept;
    logic               w_in_access;
    logic               w_rsp_done;
    logic               w_addr_err;
    logic               w_ram_ok;
    logic [BE_W-1:0]    w_wr_be;
    logic               w_ram_rd;
    logic [c_IDX_W-1:0] w_idx;
    logic [DATA_W-1:0]  w_ram_rdata;

    assign w_accept    = req_valid && (r_state == IDLE);
    assign w_in_access = (r_state == ACCESS);
    assign w_rsp_done  = (r_state == RESP) && rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (c_WAIT == 4'd0) begin
                        w_state_nxt = ACCESS;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = c_WAIT;
                    end
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) w_state_nxt = ACCESS;
            end
            ACCESS:  w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request fields are frozen at the accept edge for the whole transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
        end
    end

    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_idx_full
            assign w_idx = r_addr;
        end else begin : g_idx_wrap
            localparam logic [ADDR_W-1:0] c_DEPTH_A = ADDR_W'(DEPTH);
            assign w_idx = c_IDX_W'(r_addr % c_DEPTH_A);
        end
    endgenerate

`ifdef DM_ERR_EN
    localparam logic [ADDR_W:0] c_DEPTH_X = (ADDR_W+1)'(DEPTH);
    logic r_err;

    assign w_addr_err = ({1'b0, r_addr} >= c_DEPTH_X);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_err <= 1'b0;
        else if (w_in_access) r_err <= w_addr_err;
        else if (w_rsp_done)  r_err <= 1'b0;
    end

    assign rsp_err = r_err;
`else
    assign w_addr_err = 1'b0;
    assign rsp_err    = 1'b0;
`endif

    // rst gating keeps a write from landing on the edge that reset is held.
    assign w_ram_ok = w_in_access && !w_addr_err && !rst;
    assign w_wr_be  = (w_ram_ok && r_we) ? r_be : '0;
    assign w_ram_rd = w_ram_ok && !r_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_rsp_load <= 1'b0;
        else if (w_in_access) r_rsp_load <= !r_we && !w_addr_err;
        else if (w_rsp_done)  r_rsp_load <= 1'b0;
    end

    dm_ram_array #(
        .DEPTH (DEPTH),
        .IDX_W (c_IDX_W)
    ) u_ram (
        .clk     (clk),
        .i_wr_be (w_wr_be),
        .i_rd_en (w_ram_rd),
        .i_addr  (w_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    // The RAM read register only updates in ACCESS, so the load data holds through RESP.
    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rsp_load ? w_ram_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_dm_wait_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_wait_responder
// Description : Self-checking bench for dm_wait_responder (WAIT_CYCLES=2 and 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_wait_responder;

    localparam int c_AW    = 10;
    localparam int c_DEPTH = 512;
    localparam int c_WAIT  = 2;

    logic clk = 1'b0;
    logic rst;

    logic        req_valid, req_ready, req_we;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        b_req_valid, b_req_ready, b_req_we;
    logic [9:0]  b_req_addr;
    logic [31:0] b_req_wdata;
    logic [3:0]  b_req_be;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    dm_wait_responder #(.ADDR_W(c_AW), .DATA_W(32), .DEPTH(c_DEPTH), .WAIT_CYCLES(c_WAIT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dm_wait_responder #(.ADDR_W(c_AW), .DATA_W(32), .DEPTH(c_DEPTH), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .req_be(b_req_be),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model of the WAIT_CYCLES=2 instance ----------------
    logic [31:0] m_mem [c_DEPTH];
    bit          m_busy = 1'b0;
    bit          m_vis  = 1'b0;
    int          m_acc;
    bit          m_we;
    logic [9:0]  m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic [31:0] m_rdata;
    bit          m_err;

    function automatic bit addr_bad(input logic [9:0] a);
`ifdef DM_ERR_EN
        return int'(a) >= c_DEPTH;
`else
        return (a != a);
`endif
    endfunction

    // A request takes effect when its response appears; a reset before that cancels it.
    initial begin
        for (int i = 0; i < c_DEPTH; i++) m_mem[i] = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_busy = 1'b0;
                m_vis  = 1'b0;
                chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
                chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
                chk("rst_rsp_rdata", rsp_rdata, 32'd0);
                chk("rst_rsp_err",   {31'b0, rsp_err}, 32'd0);
            end else begin
                if (m_busy && !m_vis && cyc == m_acc + c_WAIT + 2) begin
                    int idx;
                    idx     = int'(m_addr) % c_DEPTH;
                    m_vis   = 1'b1;
                    m_err   = addr_bad(m_addr);
                    m_rdata = 32'h0;
                    if (!m_err) begin
                        if (m_we) begin
                            for (int l = 0; l < 4; l++)
                                if (m_be[l]) m_mem[idx][l*8 +: 8] = m_wdata[l*8 +: 8];
                        end else begin
                            m_rdata = m_mem[idx];
                        end
                    end
                end
                chk("req_ready", {31'b0, req_ready}, {31'b0, !m_busy});
                chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_vis});
                if (m_vis) begin
                    chk("rsp_rdata", rsp_rdata, m_rdata);
                    chk("rsp_err", {31'b0, rsp_err}, {31'b0, m_err});
                end
                if (m_vis && rsp_ready) begin
                    m_busy = 1'b0;
                    m_vis  = 1'b0;
                end else if (!m_busy && req_valid) begin
                    m_busy  = 1'b1;
                    m_acc   = cyc;
                    m_we    = req_we;
                    m_addr  = req_addr;
                    m_wdata = req_wdata;
                    m_be    = req_be;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (req_ready && req_valid) ok = 1'b1;
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1'b1;
        end
        if (!ok) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_req(input bit we, input logic [9:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, output logic [31:0] rd, output logic er,
                          output int lat);
        bit ok;
        int acc;
        rd = 32'h0; er = 1'b0; lat = -1;
        req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
        req_valid = 1'b1; rsp_ready = 1'b1;
        wait_accept(ok);
        acc = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        // scramble the request bus; the in-flight access must not notice
        req_we = ~we; req_addr = ~addr; req_wdata = ~wd; req_be = ~be;
        if (!ok) return;
        wait_rsp(ok);
        if (!ok) return;
        lat = cyc - acc;
        rd  = rsp_rdata;
        er  = rsp_err;
        @(posedge clk); #1;
    endtask

    task automatic backpressure(input logic [9:0] addr, input logic [31:0] exp,
                                input logic [9:0] addr2, input logic [31:0] exp2);
        bit ok;
        int acc, hs;
        req_we = 1'b0; req_addr = addr; req_be = 4'hF; req_valid = 1'b1; rsp_ready = 1'b0;
        wait_accept(ok);
        if (!ok) return;
        acc = cyc;
        @(posedge clk); #1;
        req_addr = addr2;
        wait_rsp(ok);
        if (!ok) return;
        chk("bp_latency", 32'(cyc - acc), 32'(c_WAIT + 2));
        chk("bp_rdata_first", rsp_rdata, exp);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            req_valid = ~req_valid;
            @(negedge clk);
            chk("bp_rsp_valid_held", {31'b0, rsp_valid}, 32'd1);
            chk("bp_rdata_held", rsp_rdata, exp);
            chk("bp_req_ready_low", {31'b0, req_ready}, 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1; req_valid = 1'b1;
        @(negedge clk);
        hs = cyc;
        chk("bp_no_accept_at_rsp", {31'b0, req_ready}, 32'd0);
        wait_accept(ok);
        if (!ok) return;
        chk("bp_accept_gap", 32'(cyc - hs), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_rsp(ok);
        if (!ok) return;
        chk("bp_second_rdata", rsp_rdata, exp2);
        @(posedge clk); #1;
    endtask

    task automatic rst_mid(input logic [9:0] addr, input logic [31:0] wd, input int n_edges);
        bit ok;
        req_we = 1'b1; req_addr = addr; req_wdata = wd; req_be = 4'hF;
        req_valid = 1'b1; rsp_ready = 1'b1;
        wait_accept(ok);
        for (int k = 0; k < n_edges; k++) begin
            @(posedge clk);
            if (k == 0) begin #1; req_valid = 1'b0; end
        end
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("async_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("async_rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("async_rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // ---------------- WAIT_CYCLES=0 instance ----------------
    bit          b_we_v  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] b_wd_v  [4] = '{32'h0BADCAFE, 32'h0, 32'h77000000, 32'h0};
    logic [3:0]  b_be_v  [4] = '{4'hF, 4'hF, 4'h8, 4'hF};
    logic [31:0] b_exp_v [4] = '{32'h0, 32'h0BADCAFE, 32'h0, 32'h77ADCAFE};

    task automatic b_run();
        bit ok;
        int acc;
        int prev = 0;
        b_rsp_ready = 1'b1; b_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b_req_we = b_we_v[k]; b_req_addr = 10'd2; b_req_wdata = b_wd_v[k]; b_req_be = b_be_v[k];
            ok = 1'b0;
            for (int n = 0; n < 20 && !ok; n++) begin
                @(negedge clk);
                if (b_req_ready) ok = 1'b1;
            end
            if (!ok) begin chk("b_accept_timeout", 32'd0, 32'd1); break; end
            acc = cyc;
            if (k > 0) chk("b_spacing", 32'(acc - prev), 32'd3);
            prev = acc;
            ok = 1'b0;
            for (int n = 0; n < 20 && !ok; n++) begin
                @(negedge clk);
                if (b_rsp_valid) ok = 1'b1;
            end
            if (!ok) begin chk("b_rsp_timeout", 32'd0, 32'd1); break; end
            chk("b_latency", 32'(cyc - acc), 32'd2);
            chk("b_rdata", b_rsp_rdata, b_exp_v[k]);
            @(posedge clk); #1;
        end
        b_req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
        b_rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_b_req_ready", {31'b0, b_req_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        do_req(1'b1, 10'd5, 32'hDEADBEEF, 4'hF, rd, er, lat);
        chk("store_latency", 32'(lat), 32'd4);
        chk("store_rdata_zero", rd, 32'd0);
        do_req(1'b0, 10'd5, 32'h0, 4'hF, rd, er, lat);
        chk("load_latency", 32'(lat), 32'd4);
        chk("load_full", rd, 32'hDEADBEEF);

        do_req(1'b1, 10'd5, 32'h11223344, 4'b0101, rd, er, lat);
        do_req(1'b0, 10'd5, 32'h0, 4'hF, rd, er, lat);
        chk("load_partial", rd, 32'hDE22BE44);

        do_req(1'b1, 10'd5, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        chk("be0_still_responds", 32'(lat), 32'd4);
        do_req(1'b0, 10'd5, 32'h0, 4'hF, rd, er, lat);
        chk("load_after_be0", rd, 32'hDE22BE44);

        do_req(1'b1, 10'd7, 32'h00007777, 4'hF, rd, er, lat);
        backpressure(10'd5, 32'hDE22BE44, 10'd7, 32'h00007777);

        do_req(1'b1, 10'd9, 32'h0, 4'hF, rd, er, lat);
        rst_mid(10'd9, 32'hCAFEF00D, 1);
        do_req(1'b0, 10'd9, 32'h0, 4'hF, rd, er, lat);
        chk("rst_in_wait_no_store", rd, 32'h0);

        do_req(1'b1, 10'd10, 32'h0, 4'hF, rd, er, lat);
        rst_mid(10'd10, 32'h12345678, c_WAIT + 1);
        do_req(1'b0, 10'd10, 32'h0, 4'hF, rd, er, lat);
        chk("rst_in_access_no_store", rd, 32'h0);

        do_req(1'b1, 10'd88, 32'hA5A5A5A5, 4'hF, rd, er, lat);
        do_req(1'b1, 10'd600, 32'h600D600D, 4'hF, rd, er, lat);
        chk("hi_store_latency", 32'(lat), 32'd4);
`ifdef DM_ERR_EN
        chk("hi_store_err", {31'b0, er}, 32'd1);
        chk("hi_store_rdata", rd, 32'd0);
        do_req(1'b0, 10'd600, 32'h0, 4'hF, rd, er, lat);
        chk("hi_load_err", {31'b0, er}, 32'd1);
        chk("hi_load_rdata", rd, 32'd0);
        do_req(1'b0, 10'd88, 32'h0, 4'hF, rd, er, lat);
        chk("addr88_unchanged", rd, 32'hA5A5A5A5);
        chk("addr88_err", {31'b0, er}, 32'd0);
`else
        chk("hi_store_err", {31'b0, er}, 32'd0);
        do_req(1'b0, 10'd88, 32'h0, 4'hF, rd, er, lat);
        chk("wrap_readback", rd, 32'h600D600D);
        chk("wrap_err", {31'b0, er}, 32'd0);
`endif

        b_run();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
